// File: rtl/conv_cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_cfg_pkg                                               |
// | Description : Shared types, default widths and sizing helpers for the    |
// |               convolution configuration loader.                          |
// | Contents    : cfg_state_t   - loader FSM state encoding                  |
// |               calc_k_words  - words needed to carry the kernel bytes     |
// |               calc_cnt_width- word-counter width for both load phases    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package conv_cfg_pkg;

  localparam int c_DEF_WORD_WIDTH = 32;
  localparam int c_DEF_BYTE_WIDTH = 8;
  localparam int c_DEF_C_WIDTH    = 16;
  localparam int c_DEF_N_WIDTH    = 8;
  localparam int c_DEF_M0_WORDS   = 2;
  localparam int c_DEF_K_BYTES    = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M0 = 3'd1,
    LOAD_CN = 3'd2,
    LOAD_K  = 3'd3,
    COMMIT  = 3'd4
  } cfg_state_t;

  // Ceiling division: number of stream words that carry all kernel bytes.
  function automatic int calc_k_words(input int k_bytes, input int byte_w, input int word_w);
    return (k_bytes * byte_w + word_w - 1) / word_w;
  endfunction

  // One counter serves both multi-word phases, so size it for the longer one.
  function automatic int calc_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : word_shift_reg                                             |
// | Description : Word-granular left-shifting register. Each enabled cycle   |
// |               shifts the contents up one word and inserts i_data at the  |
// |               least-significant word, so the first word ends up MS.      |
// | Ports       : clk, rst_n (async, active low), i_en, i_data[WIDTH],       |
// |               o_q[OUT_WIDTH] = most-significant OUT_WIDTH bits           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module word_shift_reg #(
  parameter int WIDTH     = 32,
  parameter int WORDS     = 2,
  parameter int OUT_WIDTH = WIDTH * WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [WIDTH-1:0]     i_data,
  output logic [OUT_WIDTH-1:0] o_q
);

  localparam int c_TOT = WIDTH * WORDS;

  logic [c_TOT-1:0] r_q;

  generate
    if (WORDS == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_en) begin
          r_q <= i_data;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_en) begin
          r_q <= {r_q[c_TOT-WIDTH-1:0], i_data};
        end
      end
    end
  endgenerate

  // Surplus LS bits of the final word are simply never presented.
  assign o_q = r_q[c_TOT-1 -: OUT_WIDTH];

endmodule
`default_nettype wire

// File: rtl/conv_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_cfg_loader                                            |
// | Description : Double-buffered configuration loader. A valid/ready word   |
// |               stream fills shadow M0, C/N and kernel fields; the shadow  |
// |               bank is committed to the active bank in one cycle once the |
// |               consumer allows it. Active outputs are registers only.     |
// | Ports       : clk, rst_n        - clock, async active-low reset          |
// |               i_start, i_abort  - begin / discard a load sequence        |
// |               i_valid, i_data, o_ready - word stream handshake           |
// |               i_swap_ok         - consumer permits active-bank update    |
// |               o_busy, o_cfg_valid, o_swap - status                       |
// |               o_M0, o_N, o_C, o_K - active configuration                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv_cfg_loader
  import conv_cfg_pkg::*;
#(
  parameter int WORD_WIDTH = c_DEF_WORD_WIDTH,
  parameter int BYTE_WIDTH = c_DEF_BYTE_WIDTH,
  parameter int C_WIDTH    = c_DEF_C_WIDTH,
  parameter int N_WIDTH    = c_DEF_N_WIDTH,
  parameter int M0_WORDS   = c_DEF_M0_WORDS,
  parameter int K_BYTES    = c_DEF_K_BYTES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic                              i_valid,
  input  logic [WORD_WIDTH-1:0]             i_data,
  output logic                              o_ready,
  input  logic                              i_swap_ok,
  output logic                              o_busy,
  output logic                              o_cfg_valid,
  output logic                              o_swap,
  output logic [M0_WORDS*WORD_WIDTH-1:0]    o_M0,
  output logic [N_WIDTH-1:0]                o_N,
  output logic [C_WIDTH-1:0]                o_C,
  output logic [K_BYTES*BYTE_WIDTH-1:0]     o_K
);

  localparam int c_M0_WIDTH    = M0_WORDS * WORD_WIDTH;
  localparam int c_K_OUT_WIDTH = K_BYTES * BYTE_WIDTH;
  localparam int c_K_WORDS     = calc_k_words(K_BYTES, BYTE_WIDTH, WORD_WIDTH);
  localparam int c_CNT_W       = calc_cnt_width(M0_WORDS, c_K_WORDS);

  localparam logic [c_CNT_W-1:0] c_M0_LAST = c_CNT_W'(M0_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_K_LAST  = c_CNT_W'(c_K_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  cfg_state_t             r_state;
  cfg_state_t             w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;

  logic                   w_ready;
  logic                   w_xfer;
  logic                   w_m0_en;
  logic                   w_cn_en;
  logic                   w_k_en;
  logic                   w_commit;

  logic [c_M0_WIDTH-1:0]    w_sh_m0;
  logic [c_K_OUT_WIDTH-1:0] w_sh_k;
  logic [C_WIDTH-1:0]       r_sh_c;
  logic [N_WIDTH-1:0]       r_sh_n;

  logic [c_M0_WIDTH-1:0]    r_act_m0;
  logic [c_K_OUT_WIDTH-1:0] r_act_k;
  logic [C_WIDTH-1:0]       r_act_c;
  logic [N_WIDTH-1:0]       r_act_n;
  logic                     r_cfg_valid;
  logic                     r_swap;

  // ready already excludes abort, so a transfer can never coincide with one
  assign w_xfer = i_valid & w_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if ((r_state != IDLE) && i_abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            w_state_nxt = LOAD_M0;
            w_cnt_nxt   = '0;
          end
        end
        LOAD_M0: begin
          if (w_xfer) begin
            if (r_cnt == c_M0_LAST) begin
              w_state_nxt = LOAD_CN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_ONE;
            end
          end
        end
        LOAD_CN: begin
          if (w_xfer) begin
            w_state_nxt = LOAD_K;
            w_cnt_nxt   = '0;
          end
        end
        LOAD_K: begin
          if (w_xfer) begin
            if (r_cnt == c_K_LAST) begin
              w_state_nxt = COMMIT;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_ONE;
            end
          end
        end
        COMMIT: begin
          if (i_swap_ok) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_ready  = 1'b0;
    w_commit = 1'b0;
    o_busy   = (r_state != IDLE);
    case (r_state)
      LOAD_M0, LOAD_CN, LOAD_K: w_ready  = ~i_abort;
      COMMIT:                   w_commit = i_swap_ok & ~i_abort;
      default: begin
        w_ready  = 1'b0;
        w_commit = 1'b0;
      end
    endcase
    w_m0_en = w_xfer & (r_state == LOAD_M0);
    w_cn_en = w_xfer & (r_state == LOAD_CN);
    w_k_en  = w_xfer & (r_state == LOAD_K);
  end

  assign o_ready = w_ready;

  // -------------------------------------------------------------- shadow bank
  word_shift_reg #(
    .WIDTH     (WORD_WIDTH),
    .WORDS     (M0_WORDS),
    .OUT_WIDTH (c_M0_WIDTH)
  ) u_sh_m0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_m0_en),
    .i_data (i_data),
    .o_q    (w_sh_m0)
  );

  word_shift_reg #(
    .WIDTH     (WORD_WIDTH),
    .WORDS     (c_K_WORDS),
    .OUT_WIDTH (c_K_OUT_WIDTH)
  ) u_sh_k (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_k_en),
    .i_data (i_data),
    .o_q    (w_sh_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_c <= '0;
      r_sh_n <= '0;
    end else if (w_cn_en) begin
      r_sh_c <= i_data[C_WIDTH+N_WIDTH-1:N_WIDTH];
      r_sh_n <= i_data[N_WIDTH-1:0];
    end
  end

  // -------------------------------------------------------------- active bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_m0    <= '0;
      r_act_k     <= '0;
      r_act_c     <= '0;
      r_act_n     <= '0;
      r_cfg_valid <= 1'b0;
      r_swap      <= 1'b0;
    end else begin
      r_swap <= w_commit;
      if (w_commit) begin
        r_act_m0    <= w_sh_m0;
        r_act_k     <= w_sh_k;
        r_act_c     <= r_sh_c;
        r_act_n     <= r_sh_n;
        r_cfg_valid <= 1'b1;
      end
    end
  end

  assign o_M0        = r_act_m0;
  assign o_K         = r_act_k;
  assign o_C         = r_act_c;
  assign o_N         = r_act_n;
  assign o_cfg_valid = r_cfg_valid;
  assign o_swap      = r_swap;

endmodule
`default_nettype wire

// File: tb/tb_conv_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_conv_cfg_loader                                         |
// | Description : Self-checking bench for conv_cfg_loader. A transaction-    |
// |               level model (queue of accepted words) predicts every       |
// |               output each cycle; directed literal checks pin the model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_conv_cfg_loader;

  localparam int WW    = 32;
  localparam int M0W   = 2;
  localparam int KW    = 3;
  localparam int KOW   = 72;
  localparam int TOTAL = M0W + 1 + KW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          i_start   = 1'b0;
  logic          i_abort   = 1'b0;
  logic          i_valid   = 1'b0;
  logic          i_swap_ok = 1'b0;
  logic [WW-1:0] i_data    = '0;

  logic          o_ready, o_busy, o_cfg_valid, o_swap;
  logic [63:0]   o_M0;
  logic [7:0]    o_N;
  logic [15:0]   o_C;
  logic [KOW-1:0] o_K;

  always #5 clk = ~clk;

  conv_cfg_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .i_swap_ok   (i_swap_ok),
    .o_busy      (o_busy),
    .o_cfg_valid (o_cfg_valid),
    .o_swap      (o_swap),
    .o_M0        (o_M0),
    .o_N         (o_N),
    .o_C         (o_C),
    .o_K         (o_K)
  );

  int total  = 0;
  int bad    = 0;
  int n_swap = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic            m_busy  = 1'b0;
  logic [WW-1:0]   m_words [$];
  logic [63:0]     e_m0    = '0;
  logic [15:0]     e_c     = '0;
  logic [7:0]      e_n     = '0;
  logic [KOW-1:0]  e_k     = '0;
  logic            e_cfg   = 1'b0;
  logic            e_swap  = 1'b0;
  logic [63:0]     t_m0;
  logic [95:0]     t_k;
  logic [WW-1:0]   t_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_words.delete();
      e_m0 = '0; e_c = '0; e_n = '0; e_k = '0; e_cfg = 1'b0; e_swap = 1'b0;
    end else begin
      e_swap = 1'b0;
      if (!m_busy) begin
        if (i_start && !i_abort) begin
          m_busy = 1'b1;
          m_words.delete();
        end
      end else if (i_abort) begin
        m_busy = 1'b0;
      end else if (m_words.size() < TOTAL) begin
        if (i_valid) m_words.push_back(i_data);
      end else if (i_swap_ok) begin
        t_m0 = '0;
        for (int i = 0; i < M0W; i++) t_m0 = (t_m0 << WW) | 64'(m_words[i]);
        t_w = m_words[M0W];
        t_k = '0;
        for (int i = 0; i < KW; i++) t_k = (t_k << WW) | 96'(m_words[M0W+1+i]);
        e_m0   = t_m0;
        e_c    = t_w[23:8];
        e_n    = t_w[7:0];
        e_k    = t_k[95 -: KOW];
        e_cfg  = 1'b1;
        e_swap = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // ----------------------------------------------------------- compare process
  always @(negedge clk) begin
    chk("ready", o_ready, m_busy && (m_words.size() < TOTAL) && !i_abort);
    chk("busy",  o_busy,  m_busy);
    chk("swap",  o_swap,  e_swap);
    chk("cfgv",  o_cfg_valid, e_cfg);
    chk("m0",    o_M0, e_m0);
    chk("c",     o_C,  e_c);
    chk("n",     o_N,  e_n);
    chk("k",     o_K,  e_k);
    if (o_swap) n_swap++;
  end

  // ------------------------------------------------------------------ drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input int gap);
    bit ok;
    repeat (gap) begin
      i_valid = 1'b0;
      i_data  = $urandom;
      step();
    end
    i_valid = 1'b1;
    i_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=ready_low want=ready_high");
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: two idle cycles before odd words, 2: random gaps
  task automatic send_words(input logic [WW-1:0] w [TOTAL], input int first, input int last,
                            input int mode);
    int g;
    for (int i = first; i < last; i++) begin
      g = (mode == 0) ? 0 : (mode == 1) ? ((i % 2) ? 2 : 0) : int'($urandom_range(0, 2));
      send_word(w[i], g);
    end
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  logic [WW-1:0] W1 [TOTAL];
  logic [WW-1:0] W2 [TOTAL];
  logic [WW-1:0] WR [TOTAL];

  initial begin
    W1 = '{32'h11111111, 32'h22222222, 32'h00ABCD05, 32'hA0A1A2A3, 32'hA4A5A6A7, 32'hA8FFFFFF};
    W2 = '{32'h01234567, 32'h89ABCDEF, 32'hFF123478, 32'h01020304, 32'h05060708, 32'h09000000};

    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", o_ready, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_cfgv",  o_cfg_valid, 0);
    chk("rst_m0",    o_M0, 0);
    chk("rst_k",     o_K, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Gap-free load with swap permitted
    i_swap_ok = 1'b1;
    start_pulse();
    send_words(W1, 0, TOTAL, 0);
    chk("t1_noswap_yet", o_swap, 0);
    step();
    chk("t1_swap_pulse", o_swap, 1);
    chk("t1_m0", o_M0, 64'h1111111122222222);
    chk("t1_c",  o_C, 16'hABCD);
    chk("t1_n",  o_N, 8'h05);
    chk("t1_k",  o_K, 72'hA0A1A2A3A4A5A6A7A8);
    step();
    chk("t1_swap_once", o_swap, 0);
    chk("t1_cfgv", o_cfg_valid, 1);
    chk("t1_nswap", n_swap, 1);

    // Commit held off by the consumer
    i_swap_ok = 1'b0;
    start_pulse();
    send_words(W2, 0, TOTAL, 0);
    repeat (5) step();
    chk("t2_hold_ready", o_ready, 0);
    chk("t2_hold_m0", o_M0, 64'h1111111122222222);
    chk("t2_hold_nswap", n_swap, 1);
    i_swap_ok = 1'b1;
    step();
    chk("t2_swap", o_swap, 1);
    chk("t2_m0", o_M0, 64'h0123456789ABCDEF);
    chk("t2_c",  o_C, 16'h1234);
    chk("t2_n",  o_N, 8'h78);
    chk("t2_k",  o_K, 72'h010203040506070809);

    // Toggling i_valid during the loads
    start_pulse();
    send_words(W1, 0, TOTAL, 1);
    repeat (2) step();
    chk("t3_m0", o_M0, 64'h1111111122222222);
    chk("t3_k",  o_K, 72'hA0A1A2A3A4A5A6A7A8);
    chk("t3_nswap", n_swap, 3);

    // Abort after three words, then a full reload
    start_pulse();
    send_words(W2, 0, 3, 0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("t4_abort_busy", o_busy, 0);
    chk("t4_abort_m0", o_M0, 64'h1111111122222222);
    start_pulse();
    send_words(W2, 0, TOTAL, 2);
    repeat (2) step();
    chk("t4_m0", o_M0, 64'h0123456789ABCDEF);
    chk("t4_c",  o_C, 16'h1234);

    // i_start during LOAD_K and COMMIT is ignored
    i_swap_ok = 1'b0;
    start_pulse();
    send_words(W1, 0, M0W + 1, 0);
    i_start = 1'b1;
    send_words(W1, M0W + 1, TOTAL, 0);
    repeat (3) step();
    i_start = 1'b0;
    chk("t5_busy", o_busy, 1);
    chk("t5_m0_held", o_M0, 64'h0123456789ABCDEF);
    i_swap_ok = 1'b1;
    step();
    i_swap_ok = 1'b0;
    chk("t5_m0", o_M0, 64'h1111111122222222);
    step();
    chk("t5_idle", o_busy, 0);

    // Randomized loads with random aborts (including in COMMIT) and swap delays
    for (int it = 0; it < 30; it++) begin
      int n;
      bit ab;
      for (int i = 0; i < TOTAL; i++) WR[i] = $urandom;
      ab = ($urandom_range(0, 3) == 0);
      n  = ab ? int'($urandom_range(0, TOTAL)) : TOTAL;
      i_swap_ok = 1'b0;
      start_pulse();
      send_words(WR, 0, n, 2);
      if (ab) begin
        i_abort   = 1'b1;
        i_swap_ok = $urandom_range(0, 1);
        step();
        i_abort   = 1'b0;
        i_swap_ok = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) step();
        i_swap_ok = 1'b1;
        step();
        i_swap_ok = 1'b0;
      end
      step();
    end

    // Asynchronous reset in the middle of LOAD_K
    start_pulse();
    send_words(W2, 0, M0W + 2, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t7_busy", o_busy, 0);
    chk("t7_ready", o_ready, 0);
    chk("t7_cfgv", o_cfg_valid, 0);
    chk("t7_m0", o_M0, 0);
    chk("t7_k",  o_K, 0);
    step();
    rst_n = 1'b1;
    step();

    // Recovery after reset
    i_swap_ok = 1'b1;
    start_pulse();
    send_words(W2, 0, TOTAL, 2);
    repeat (2) step();
    chk("t8_k", o_K, 72'h010203040506070809);
    chk("t8_cfgv", o_cfg_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/conv_cfg_loader.md
Name: conv_cfg_loader

Overview:
- Double-buffered configuration loader for the convolution datapath.
- Accepts a valid/ready word stream, sequences it into shadow M0 / C,N / kernel fields via an FSM, then commits shadow to active in one cycle when the consumer permits.
- Active outputs stay stable during reload; sits between the host/DMA word port and the conv engine.

Parameters:
- WORD_WIDTH, 32, stream word width
- BYTE_WIDTH, 8, kernel element width
- C_WIDTH, 16, channel-count field width
- N_WIDTH, 8, shift/N field width; C_WIDTH+N_WIDTH <= WORD_WIDTH
- M0_WORDS, 2, words forming M0 (M0_WIDTH = M0_WORDS*WORD_WIDTH)
- K_BYTES, 9, kernel bytes, integer >= 1 (K_OUT_WIDTH = K_BYTES*BYTE_WIDTH)
- Derived localparam K_WORDS = ceil(K_OUT_WIDTH/WORD_WIDTH), computed by integer arithmetic.

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- i_start, in, 1, begin a load sequence; honoured only in IDLE
- i_abort, in, 1, discard the in-progress load
- i_valid, in, 1, i_data valid
- i_data, in, WORD_WIDTH, stream word
- o_ready, out, 1, loader accepts a word this cycle
- i_swap_ok, in, 1, consumer permits the active-bank update
- o_busy, out, 1, FSM not in IDLE
- o_cfg_valid, out, 1, active bank holds a committed configuration
- o_swap, out, 1, one-cycle pulse coincident with new active values
- o_M0, out, M0_WIDTH, active M0
- o_N, out, N_WIDTH, active N
- o_C, out, C_WIDTH, active C
- o_K, out, K_OUT_WIDTH, active kernel

Behaviour:
- Reset (asynchronous, rst_n=0): FSM to IDLE, counter=0, shadow and active banks all 0, o_cfg_valid=0, o_swap=0, o_ready=0.
- Transfer: a word moves when i_valid & o_ready. o_ready=1 only in LOAD_M0, LOAD_CN and LOAD_K, and only when i_abort=0. It is combinational from state and i_abort.
- IDLE: i_start -> LOAD_M0, counter=0.
- LOAD_M0: each transfer shifts the shadow M0 left by one word and inserts i_data at the LS word, so the first word ends up MS. Counter increments. Transfer with counter==M0_WORDS-1 -> LOAD_CN, counter=0.
- LOAD_CN: one transfer. shadow C = i_data[C_WIDTH+N_WIDTH-1:N_WIDTH], shadow N = i_data[N_WIDTH-1:0]. Then -> LOAD_K.
- LOAD_K: shifts the K_WORDS*WORD_WIDTH shadow kernel register the same way as M0. Transfer with counter==K_WORDS-1 -> COMMIT. o_K takes the MS K_OUT_WIDTH bits; surplus LS bits of the last word are dropped.
- COMMIT: o_ready=0. If i_swap_ok=1, copy shadow to active at that clock edge and return to IDLE. Otherwise hold in COMMIT indefinitely.
- Commit outputs: o_swap and the new o_M0/o_N/o_C/o_K become visible the cycle after the commit edge. o_swap is high for exactly one cycle. o_cfg_valid is set and stays 1 until reset.
- Latency: last K word accepted at edge t; COMMIT during cycle t..t+1. With i_swap_ok=1 in that cycle, new outputs and o_swap appear after edge t+1. Total 1 cycle when swap is permitted.
- i_abort in any non-IDLE state, including COMMIT: -> IDLE, counter=0, no transfer that cycle, active bank and o_cfg_valid unchanged. Shadow contents are don't-care.
- Priority: i_abort over i_swap_ok.
- i_start outside IDLE: ignored. i_start together with i_abort in IDLE: abort wins, stay IDLE.
- i_valid=0 during a LOAD state: hold state and counter (stall), with no timeout.
- Shadow is not cleared on i_start. Every shadow bit is overwritten by a complete sequence.
- Reset mid-load: the active bank is cleared too and o_cfg_valid=0.
- Counter width: $clog2 of max(M0_WORDS, K_WORDS), minimum 1 bit.
- Active-bank outputs are driven directly from registers, with no combinational path from inputs.

Decomposition:
- conv_cfg_pkg holds:
  - the state enum typedef (IDLE, LOAD_M0, LOAD_CN, LOAD_K, COMMIT);
  - a function computing K_WORDS from K_BYTES, BYTE_WIDTH and WORD_WIDTH;
  - default width constants.
- One sub-module is natural: word_shift_reg. It is a parametrised WIDTH/WORDS left-shifting word register with enable and async reset, instantiated for shadow M0 and shadow K.
- The FSM, counter and active bank stay in the top module.

Test Plan:
- Reset, then idle: all outputs 0, o_ready=0, o_busy=0, o_cfg_valid=0.
- Full load, defaults, i_swap_ok=1, words 0x11111111, 0x22222222, 0x00ABCD05, 0xA0A1A2A3, 0xA4A5A6A7, 0xA8FFFFFF. Required: o_M0=0x1111111122222222, o_C=0xABCD, o_N=0x05, o_K=0xA0A1A2A3A4A5A6A7A8, one o_swap pulse, o_cfg_valid=1.
- i_swap_ok=0 for 5 cycles after the last word: o_ready=0, old active values held, no o_swap. Raise i_swap_ok: update plus pulse on the next cycle.
- i_valid toggling 1,0,0,1 during LOAD_M0 and LOAD_K: same final values as the gap-free load, with no extra words consumed.
- i_abort after 3 words, then a full reload of different data: active keeps its prior values until the second commit, and the second commit is correct.
- i_start asserted during LOAD_K and during COMMIT: no effect. Async reset asserted mid-LOAD_K: all outputs 0 immediately, FSM in IDLE.
